// File: rtl/spi_master_tx.sv
// rtl/spi_master_tx.sv - LSB-first 12-bit SPI frame transmitter with post-reset slave flush
module spi_master_tx #(
  parameter int DATA_W  = 12,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              cs,
  output logic              mosi
);

  typedef enum logic [2:0] {FLUSH, IDLE, SETUP, SHIFT, GUARD} state_t;

  localparam int               DIV_W      = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_MAX    = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       LAST_PULSE = 4'(DATA_W + 1);
  localparam logic [3:0]       DATA_END   = 4'(DATA_W);

  state_t            state;
  logic [DIV_W-1:0]  div;
  logic [3:0]        pulse;
  logic [DATA_W-1:0] shift;
  logic              tick;

  assign tick = (div == DIV_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FLUSH;
      div   <= '0;
      pulse <= '0;
      shift <= '0;
      cs    <= 1'b1;
      sclk  <= 1'b0;
      mosi  <= 1'b0;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE || tick) div <= '0;
      else                       div <= div + 1'b1;

      case (state)
        // cs stays high, so the slave only advances its bit count back to start-detect
        FLUSH: if (tick) begin
          if (!sclk) begin
            sclk <= 1'b1;
          end else begin
            sclk <= 1'b0;
            if (pulse == LAST_PULSE) begin
              pulse <= '0;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              pulse <= pulse + 1'b1;
            end
          end
        end
        IDLE: if (start) begin
          shift <= din;
          cs    <= 1'b0;
          busy  <= 1'b1;
          pulse <= '0;
          state <= SETUP;
        end
        SETUP: if (tick) begin
          sclk  <= 1'b1;
          state <= SHIFT;
        end
        // data moves on falling edges so it is stable across the next rising edge
        SHIFT: if (tick) begin
          if (sclk) begin
            sclk <= 1'b0;
            if (pulse < DATA_END) begin
              mosi  <= shift[0];
              shift <= shift >> 1;
            end else begin
              mosi <= 1'b0;
            end
          end else if (pulse == LAST_PULSE) begin
            cs    <= 1'b1;
            state <= GUARD;
          end else begin
            pulse <= pulse + 1'b1;
            sclk  <= 1'b1;
          end
        end
        GUARD: if (tick) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= FLUSH;
      endcase
    end
  end

endmodule
